// File: rtl/ahbl_sram_slave_pkg.sv
// Shared AHB-Lite definitions: bus defaults, transfer/response encodings and slave FSM states.
package ahbl_sram_slave_pkg;

  localparam int unsigned AHB_ADDR_WIDTH  = 32;
  localparam int unsigned AHB_DATA_WIDTH  = 32;
  localparam int unsigned AHB_MEM_DEPTH   = 1024;
  localparam int unsigned AHB_WAIT_STATES = 0;
  localparam int unsigned WAIT_CNT_W      = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  // Number of byte-offset address bits for a given bus width.
  function automatic int unsigned lane_addr_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite slave-side bus bundle; HREADY is driven by the decoder/mux on the master side.
interface ahbl_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahbl_byte_lane_decode.sv
// Maps (HSIZE, low address bits) to a little-endian byte-enable vector; flags sizes wider than the bus.
module ahbl_byte_lane_decode #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]                      size_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_i,
  output logic [DATA_WIDTH/8-1:0]         be_o,
  output logic                            oversize_o
);
  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned LANE_AW = $clog2(BYTES);

  logic [2:0]       size_eff;
  logic [BYTES-1:0] mask;

  // Oversize requests are clamped to the full bus so the write path stays defined.
  always_comb begin
    oversize_o = 1'b0;
    size_eff   = size_i;
    if (size_i > 3'(LANE_AW)) begin
      oversize_o = 1'b1;
      size_eff   = 3'(LANE_AW);
    end
    mask = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (b < (32'd1 << size_eff)) mask[b] = 1'b1;
    end
    be_o = mask << addr_i;
  end
endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave with byte lanes and programmable wait states.
// Optional ERROR response for illegal transfers is enabled by defining AHBL_SLAVE_ERR_EN.
module ahbl_sram_slave
  import ahbl_sram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = AHB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = AHB_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH   = AHB_MEM_DEPTH,
  parameter int unsigned WAIT_STATES = AHB_WAIT_STATES
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahbl_sram_slave_if.slave  bus
);
  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned LANE_AW  = lane_addr_bits(DATA_WIDTH);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);

  slv_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  valid_q, write_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BYTES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  acc_c, illegal_c, oversize_c;
  logic [BYTES-1:0]      be_c;
  logic                  hreadyout_c, hresp_c, dphase_c, wr_en_c;
  logic [DATA_WIDTH-1:0] rdata_c;

  assign acc_c = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  ahbl_byte_lane_decode #(.DATA_WIDTH(DATA_WIDTH)) u_lane_dec (
    .size_i     (bus.HSIZE),
    .addr_i     (bus.HADDR[LANE_AW-1:0]),
    .be_o       (be_c),
    .oversize_o (oversize_c)
  );

`ifdef AHBL_SLAVE_ERR_EN
  assign illegal_c = oversize_c | (|bus.HADDR[ADDR_WIDTH-1:LANE_AW+IDX_W]);
  assign bus.HRESP = hresp_c;
`else
  assign illegal_c = 1'b0;
  assign bus.HRESP = HRESP_OKAY;
`endif

  // Address-phase capture; the index drops upper address bits so addresses wrap.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
    end else if (bus.HREADY) begin
      valid_q <= acc_c;
      if (acc_c) begin
        write_q <= bus.HWRITE;
        idx_q   <= bus.HADDR[LANE_AW +: IDX_W];
        be_q    <= be_c;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Erroring transfers bypass wait states and go straight to the two-cycle response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (state_q == ST_WAIT && cnt_q != '0) begin
      cnt_d = cnt_q - WAIT_CNT_W'(1);
    end else if (!acc_c) begin
      state_d = ST_IDLE;
    end else if (illegal_c) begin
      state_d = ST_ERR1;
    end else if (HAS_WAIT) begin
      state_d = ST_WAIT;
      cnt_d   = WAIT_CNT_W'(WAIT_STATES);
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    hreadyout_c = 1'b1;
    hresp_c     = HRESP_OKAY;
    case (state_q)
      ST_WAIT: hreadyout_c = (cnt_q == '0);
      ST_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = HRESP_ERROR;
      end
      ST_ERR2: hresp_c = HRESP_ERROR;
      default: ;
    endcase
    dphase_c = valid_q & hreadyout_c & ((state_q == ST_IDLE) | (state_q == ST_WAIT));
    wr_en_c  = dphase_c & write_q;
    rdata_c  = (dphase_c & ~write_q) ? mem_q[idx_q] : '0;
  end

  assign bus.HREADYOUT = hreadyout_c;
  assign bus.HRDATA    = rdata_c;

  // Write commits on the completing data-phase edge so a following read sees it.
  always_ff @(posedge HCLK) begin
    if (wr_en_c) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  logic unused_c;
  assign unused_c = ^{bus.HBURST, bus.HPROT, bus.HADDR, oversize_c, hresp_c};

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: one zero-wait and one three-wait instance on a shared master.
module tb_ahbl_sram_slave;
  import ahbl_sram_slave_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel   = 1'b0;
  logic        hsel  = 1'b0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  htrans_e     htrans = HTRANS_IDLE;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] b_addr [8];
  logic [31:0] b_wdata[8];
  logic [31:0] b_rdata[8];
  int          b_cyc  [8];
  logic        b_resp0[8];
  logic        b_resp [8];

  always #5 clk = ~clk;

  ahbl_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahbl_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  assign bus0.HSEL   = hsel & ~sel;
  assign bus3.HSEL   = hsel & sel;
  assign bus0.HADDR  = haddr;   assign bus3.HADDR  = haddr;
  assign bus0.HTRANS = htrans;  assign bus3.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;  assign bus3.HWRITE = hwrite;
  assign bus0.HSIZE  = hsize;   assign bus3.HSIZE  = hsize;
  assign bus0.HBURST = 3'd0;    assign bus3.HBURST = 3'd0;
  assign bus0.HPROT  = 4'd3;    assign bus3.HPROT  = 4'd3;
  assign bus0.HWDATA = hwdata;  assign bus3.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  logic        rdy, rsp;
  logic [31:0] rdat;
  assign rdy  = sel ? bus3.HREADYOUT : bus0.HREADYOUT;
  assign rsp  = sel ? bus3.HRESP     : bus0.HRESP;
  assign rdat = sel ? bus3.HRDATA    : bus0.HRDATA;

  ahbl_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus0)
  );
  ahbl_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pipelined burst of n beats from b_addr/b_wdata; optional BUSY/IDLE gap between beats.
  task automatic run(input bit wr, input int n, input logic [2:0] size, input bit gaps);
    @(negedge clk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = b_addr[0]; hwrite = wr; hsize = size;
    for (int i = 0; i < n; i++) begin
      int cnt;
      @(negedge clk);
      hwdata = wr ? b_wdata[i] : 32'h0;
      if (i == n - 1) begin
        hsel = 1'b0; htrans = HTRANS_IDLE;
      end else begin
        haddr = b_addr[i+1];
        if (!gaps)          htrans = HTRANS_SEQ;
        else if (i % 2 == 0) htrans = HTRANS_BUSY;
        else                htrans = HTRANS_IDLE;
      end
      b_resp0[i] = rsp;
      cnt = 0;
      while (!rdy && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      b_cyc[i]   = cnt + 1;
      b_rdata[i] = rdat;
      b_resp[i]  = rsp;
      if (gaps && i < n - 1) begin
        @(negedge clk);
        chk($sformatf("gap_rdy%0d", i), 64'(rdy), 64'd1);
        chk($sformatf("gap_resp%0d", i), 64'(rsp), 64'd0);
        if (i % 2 == 0) htrans = HTRANS_SEQ;
        else            htrans = HTRANS_NONSEQ;
      end
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
    b_addr[0] = a; b_wdata[0] = d;
    run(wr, 1, size, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy0",  64'(bus0.HREADYOUT), 64'd1);
    chk("rst_resp0", 64'(bus0.HRESP),     64'd0);
    chk("rst_data0", 64'(bus0.HRDATA),    64'd0);
    chk("rst_rdy3",  64'(bus3.HREADYOUT), 64'd1);
    rst_n = 1'b1;

    // Zero-wait word write/read
    sel = 1'b0;
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
    chk("w0_cyc", 64'(b_cyc[0]), 64'd1);
    chk("w0_resp", 64'(b_resp[0]), 64'd0);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    chk("r0_data", 64'(b_rdata[0]), 64'hDEADBEEF);
    chk("r0_cyc", 64'(b_cyc[0]), 64'd1);

    // Sub-word lanes
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'h11223344);
    xfer(1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    chk("byte3", 64'(b_rdata[0]), 64'hAA223344);
    xfer(1'b1, 32'h14, HSIZE_WORD, 32'h55667788);
    xfer(1'b1, 32'h16, HSIZE_HALF, 32'hCAFE0000);
    xfer(1'b1, 32'h15, HSIZE_BYTE, 32'h00005A00);
    xfer(1'b0, 32'h14, HSIZE_WORD, 32'h0);
    chk("half_byte1", 64'(b_rdata[0]), 64'hCAFE5A88);

    // Back-to-back write then read of the same address
    @(negedge clk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(negedge clk);
    hwdata = 32'h12345678; hwrite = 1'b0; htrans = HTRANS_NONSEQ; haddr = 32'h30;
    chk("b2b_wrdy", 64'(rdy), 64'd1);
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    chk("b2b_rdata", 64'(rdat), 64'h12345678);

    // Oversize transfer and out-of-range address
    xfer(1'b1, 32'h40, HSIZE_WORD, 32'h01020304);
    xfer(1'b1, 32'h40, HSIZE_DWORD, 32'hA5A5A5A5);
`ifdef AHBL_SLAVE_ERR_EN
    chk("osz_resp0", 64'(b_resp0[0]), 64'd1);
    chk("osz_cyc", 64'(b_cyc[0]), 64'd2);
    chk("osz_resp1", 64'(b_resp[0]), 64'd1);
    xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0);
    chk("osz_data", 64'(b_rdata[0]), 64'h01020304);
`else
    chk("osz_resp", 64'(b_resp[0]), 64'd0);
    chk("osz_cyc", 64'(b_cyc[0]), 64'd1);
    xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0);
    chk("osz_data", 64'(b_rdata[0]), 64'hA5A5A5A5);
`endif
    xfer(1'b1, 32'h0, HSIZE_WORD, 32'h0BADF00D);
    xfer(1'b1, 32'h1000, HSIZE_WORD, 32'hFFFFFFFF);
`ifdef AHBL_SLAVE_ERR_EN
    chk("oor_resp0", 64'(b_resp0[0]), 64'd1);
    chk("oor_cyc", 64'(b_cyc[0]), 64'd2);
    chk("oor_resp1", 64'(b_resp[0]), 64'd1);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0);
    chk("oor_word0", 64'(b_rdata[0]), 64'h0BADF00D);
`else
    chk("oor_resp", 64'(b_resp[0]), 64'd0);
    chk("oor_cyc", 64'(b_cyc[0]), 64'd1);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0);
    chk("oor_word0", 64'(b_rdata[0]), 64'hFFFFFFFF);
`endif

    // INCR8 write with BUSY/IDLE gaps, then plain INCR8 read
    for (int i = 0; i < 8; i++) begin
      b_addr[i] = 32'h80 + 32'(4 * i);
      b_wdata[i] = 32'hC0DE0000 | 32'(i);
    end
    run(1'b1, 8, HSIZE_WORD, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("i8w_cyc%0d", i), 64'(b_cyc[i]), 64'd1);
    run(1'b0, 8, HSIZE_WORD, 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("i8r_data%0d", i), 64'(b_rdata[i]), 64'(32'hC0DE0000 | 32'(i)));

    // Three wait states: INCR4 write and read from 0x20
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_addr[i] = 32'h20 + 32'(4 * i);
      b_wdata[i] = 32'h100 + 32'(i);
    end
    run(1'b1, 4, HSIZE_WORD, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("ws_wcyc%0d", i), 64'(b_cyc[i]), 64'd4);
    run(1'b0, 4, HSIZE_WORD, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws_rcyc%0d", i), 64'(b_cyc[i]), 64'd4);
      chk($sformatf("ws_rdata%0d", i), 64'(b_rdata[i]), 64'(32'h100 + 32'(i)));
    end
    xfer(1'b0, 32'h2C, HSIZE_WORD, 32'h0);
    chk("ws_single_cyc", 64'(b_cyc[0]), 64'd4);
    chk("ws_single_data", 64'(b_rdata[0]), 64'h103);

    // Reset during a wait state
    @(negedge clk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h24; hwrite = 1'b0; hsize = HSIZE_WORD;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    chk("mid_wait_rdy", 64'(rdy), 64'd0);
    chk("mid_wait_data", 64'(rdat), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstw_rdy", 64'(rdy), 64'd1);
    chk("rstw_resp", 64'(rsp), 64'd0);
    chk("rstw_data", 64'(rdat), 64'd0);
    @(negedge clk);
    chk("rstw_rdy_next", 64'(rdy), 64'd1);
    rst_n = 1'b1;
    xfer(1'b0, 32'h24, HSIZE_WORD, 32'h0);
    chk("post_rst3", 64'(b_rdata[0]), 64'h101);
    sel = 1'b0;
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0);
    chk("post_rst0", 64'(b_rdata[0]), 64'hAA223344);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahbl_sram_slave.md
# ahbl_sram_slave

Parametrised AHB-Lite slave that backs a word-addressed on-chip memory. It supports sub-word byte-lane writes, programmable wait states and all AHB-Lite burst types, and can optionally return an ERROR response. It sits behind the AHB-Lite decoder/mux and generalises the fixed 32-bit bus parameters in the shared package to configurable data width, depth and latency.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; legal values 32 or 64
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words; power of two
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per data phase; legal range 0..7
- HCLK  in  1  clock; all logic on the rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size, log2 of bytes
- HBURST  in  3  accepted; not used for address generation (the master drives every HADDR)
- HPROT  in  4  accepted and ignored
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase
- HREADY  in  1  bus-level ready from the mux
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  DATA_WIDTH  read data

## Operation
- **Address phase accepted** when HSEL & HREADY & HTRANS[1]. On acceptance, register HADDR, HWRITE and HSIZE, and set a valid flag.
- **IDLE or BUSY** with HSEL & HREADY: no data phase; zero-wait OKAY.
- **FSM states**: IDLE, WAIT, ERR1, ERR2.
  - IDLE → WAIT on an accepted transfer when WAIT_STATES > 0.
  - WAIT counts down WAIT_STATES cycles with HREADYOUT=0, then completes the data phase with HREADYOUT=1.
  - WAIT_STATES=0: the data phase completes in the cycle after the address phase.
- **Word index** = HADDR[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)].
- **Byte lanes**: 2^HSIZE bytes starting at HADDR modulo the bus byte width, little-endian.
- **Writes**: HWDATA enabled lanes are written in the completing data-phase cycle (HREADYOUT=1). Lanes that are not enabled keep their contents.
- **Reads**: HRDATA = full memory word, read combinationally from the registered index. HRDATA is valid whenever HREADYOUT=1 for a read data phase, and is 0 otherwise.
- **Back-to-back write A then read A**: the read returns the new data. This holds because the write commits at the end of its data phase, before the read's data phase.
- **Reset** (any cycle, including mid-wait): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, valid flag=0. Memory contents are not reset.

## Timing
- Read latency: 1 + WAIT_STATES cycles from the address phase to data sampled.
- Pipelining: the next address phase may overlap the current data phase. It is captured only when HREADY=1.
- HRESP=0 on every OKAY cycle.

## Configuration
- **AHBL_SLAVE_ERR_EN defined**: an illegal transfer gets a two-cycle ERROR response and no memory update.
  - Illegal means an out-of-range address (HADDR ≥ MEM_DEPTH × DATA_WIDTH/8) or an oversize transfer (2^HSIZE > DATA_WIDTH/8).
  - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. Then IDLE.
  - Wait states are skipped for an erroring transfer.
  - An address phase presented during ERR2 is accepted normally.
- **Not defined**: no ERROR response is ever generated; HRESP is tied to 0.
  - Addresses wrap modulo the memory size.
  - An oversize HSIZE is clamped to the full bus width.

## Structure
- Shared package additions:
  - DATA_WIDTH-generic parameters.
  - htrans_e enum (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY/HRESP_ERROR constants.
  - HSIZE constants (BYTE/HALF/WORD/DWORD).
  - FSM state typedef.
- One sub-module, ahbl_byte_lane_decode: combinational (HSIZE, low address bits) → byte-enable vector of DATA_WIDTH/8 bits. It is shared by the write path and the oversize check.

## Test plan
- WAIT_STATES=0, DATA_WIDTH=32: NONSEQ write 0xDEADBEEF to 0x10, then read 0x10 → HRDATA=0xDEADBEEF, HREADYOUT never low.
- Byte write 0xAA to 0x13 over word 0x11223344 → read 0x10 returns 0xAA223344.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, data on the 4th data-phase cycle. INCR4 from 0x20 → 4 × (1+3) data-phase cycles, sequential data correct.
- AHBL_SLAVE_ERR_EN defined, MEM_DEPTH=1024: write to 0x1000 → HRESP=1 for 2 cycles with HREADYOUT 0 then 1, and word 0 is unchanged. Without the macro, the same write lands at word 0.
- HRESETn asserted during WAIT → next cycle HREADYOUT=1, HRESP=0, HRDATA=0. Earlier memory writes are still readable after reset release.
- Interleaved IDLE and BUSY cycles between SEQ beats of an INCR8 write → zero-wait OKAY on each, all 8 words correct.
